rsa_timing_leak_monitor: RTL
============================

Name: rsa_timing_leak_monitor

Overview:
- Sits directly downstream of the two-copy RSA self-composition block.
- Consumes KeyGenStart, finish_1/finish_2 and m_decrypted_1/m_decrypted_2 from the two RSA copies, which receive different secret primes and the same message.
- Measures each copy's latency in cycles and flags any timing divergence, which is a timing side-channel leak. Also flags a result mismatch between the copies.
- Results are held until the next run is armed, for formal assertions and simulation scoreboards.

Parameters:
- WIDTH, 8: prime width of the RSA copies; message width is 2*WIDTH.
- CNT_W, 16: width of the latency counters and reported latencies.
- TIMEOUT, 16'hFFFF: maximum RUN cycles before the run is abandoned; must be at least 1 and at most 2^CNT_W-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- KeyGenStart, input, 1: run start, the same signal that drives both RSA copies.
- finish_1, input, 1: copy-1 done (level).
- finish_2, input, 1: copy-2 done (level).
- m_decrypted_1, input, 2*WIDTH: copy-1 result.
- m_decrypted_2, input, 2*WIDTH: copy-2 result.
- done, output, 1: high while in DONE.
- leak_timing, output, 1: sticky; the copies finished on different cycles, or exactly one finished before timeout.
- result_mismatch, output, 1: both copies finished and their captured results differ.
- timeout, output, 1: TIMEOUT was reached before both copies finished.
- lat_1, output, CNT_W: copy-1 latency in cycles.
- lat_2, output, CNT_W: copy-2 latency in cycles.
- delta, output, CNT_W: absolute value of lat_1 minus lat_2, valid when done=1.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. All outputs, counters, captured results and fin flags are cleared to 0.
- Reset asserted mid-run aborts the run immediately. No partial results are retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - finish_x and m_decrypted_x are ignored.
  - If KeyGenStart=1 at a clock edge, go to RUN. On that edge clear cnt, lat_1, lat_2, fin_1, fin_2, leak_timing, result_mismatch, timeout and delta.
- RUN, evaluated every cycle:
  - cnt <= cnt+1.
  - For each x, if finish_x=1 and fin_x=0: set fin_x=1, lat_x <= cnt+1, and capture m_decrypted_x into res_x. A copy whose finish is high in the first RUN cycle therefore reports lat_x=1.
  - After a copy is captured, further finish_x or m_decrypted_x activity is ignored.
  - KeyGenStart is ignored (no restart).
  - If the fin flags would differ after this cycle's update, set leak_timing=1 on this edge. Detection is immediate, not deferred to DONE.
  - If both copies finish on the same cycle, lat_1=lat_2 and leak_timing stays 0.
  - When both fin flags are set after this cycle's update, go to DONE. On entry, result_mismatch <= (res_1 != res_2), using the values captured this cycle if applicable.
  - Else if cnt+1 = TIMEOUT: go to DONE with timeout=1. Each unfinished copy gets lat_x=TIMEOUT. leak_timing=1 if exactly one copy finished, unchanged if neither finished. result_mismatch=0.
  - If the last finish and the timeout occur on the same cycle, completion wins and timeout=0.
- Counter arithmetic is unsigned CNT_W. cnt cannot wrap because TIMEOUT is at most 2^CNT_W-1.
- delta is computed as the larger latency minus the smaller and is registered on DONE entry.
- DONE:
  - done=1. All result outputs are held stable.
  - Return to IDLE only on a cycle where KeyGenStart=0. Results stay held in IDLE until the next run starts.
  - A KeyGenStart that is still high on DONE entry does not retrigger a run; it must be seen low first.
- Latency from the last finish edge to done=1 is 1 cycle (registered).

Test Plan:
- KeyGenStart high for 1 cycle, then finish_1 and finish_2 both rise in RUN cycle 7, both results 16'h0041 -> done=1, lat_1=lat_2=7, delta=0, leak_timing=0, result_mismatch=0, timeout=0.
- finish_1 rises in RUN cycle 5 and finish_2 in cycle 9 -> leak_timing=1 at the edge of cycle 5, done after cycle 9, lat_1=5, lat_2=9, delta=4.
- Both finish in cycle 3 with m_decrypted_1=16'h0041 and m_decrypted_2=16'h0042 -> result_mismatch=1, leak_timing=0.
- TIMEOUT=20, finish_1 in cycle 4, finish_2 never -> done at cycle 20, timeout=1, lat_1=4, lat_2=20, delta=16, leak_timing=1.
- rst_n pulsed low in RUN cycle 3 -> all outputs read 0 asynchronously; the next KeyGenStart starts a clean run with cnt from 0.
- KeyGenStart held high through DONE, with finish pulses while in IDLE -> no retrigger until KeyGenStart goes low. finish pulses in IDLE leave lat_1 and lat_2 unchanged.

Source files
------------

// File: rtl/rsa_timing_leak_monitor.sv
// -----------------------------------------------------------------------------
// rsa_timing_leak_monitor
//
// Observes the two copies of the RSA self-composition block. Both copies get
// the same message and different secret primes. The monitor measures how many
// cycles each copy takes and raises leak_timing when the copies finish on
// different cycles. That divergence is a timing side channel. It also flags
// a result mismatch between the copies. Results stay held after the run ends
// until the next run is armed.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   KeyGenStart      run start (shared with both RSA copies)
//   finish_1/2       per-copy done level
//   m_decrypted_1/2  per-copy result, 2*WIDTH bits
//   done             high while in DONE
//   leak_timing      sticky: copies finished on different cycles, or only
//                    one finished before the timeout
//   result_mismatch  both finished and captured results differ
//   timeout          TIMEOUT reached before both copies finished
//   lat_1/lat_2      per-copy latency in cycles (CNT_W bits)
//   delta            |lat_1 - lat_2|, valid while done=1
// -----------------------------------------------------------------------------
module rsa_timing_leak_monitor #(
  parameter int          WIDTH   = 8,
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               KeyGenStart,
  input  logic               finish_1,
  input  logic               finish_2,
  input  logic [2*WIDTH-1:0] m_decrypted_1,
  input  logic [2*WIDTH-1:0] m_decrypted_2,
  output logic               done,
  output logic               leak_timing,
  output logic               result_mismatch,
  output logic               timeout,
  output logic [CNT_W-1:0]   lat_1,
  output logic [CNT_W-1:0]   lat_2,
  output logic [CNT_W-1:0]   delta
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Unsigned distance between two latencies, larger minus smaller.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               fin_1;
  logic               fin_2;
  logic [2*WIDTH-1:0] res_1;
  logic [2*WIDTH-1:0] res_2;

  // Next-cycle view of the RUN bookkeeping, shared by the completion,
  // leak and timeout decisions so they all see this cycle's captures.
  logic [CNT_W-1:0]   cnt_inc;
  logic               cap_1;
  logic               cap_2;
  logic               fin_1_nx;
  logic               fin_2_nx;
  logic [CNT_W-1:0]   lat_1_nx;
  logic [CNT_W-1:0]   lat_2_nx;
  logic [2*WIDTH-1:0] res_1_nx;
  logic [2*WIDTH-1:0] res_2_nx;
  logic               both_fin;
  logic               hit_limit;
  logic [CNT_W-1:0]   lat_1_end;
  logic [CNT_W-1:0]   lat_2_end;

  always_comb begin
    cnt_inc   = cnt + ONE_C;
    cap_1     = finish_1 & ~fin_1;
    cap_2     = finish_2 & ~fin_2;
    fin_1_nx  = fin_1 | finish_1;
    fin_2_nx  = fin_2 | finish_2;
    lat_1_nx  = cap_1 ? cnt_inc : lat_1;
    lat_2_nx  = cap_2 ? cnt_inc : lat_2;
    res_1_nx  = cap_1 ? m_decrypted_1 : res_1;
    res_2_nx  = cap_2 ? m_decrypted_2 : res_2;
    both_fin  = fin_1_nx & fin_2_nx;
    // Completion takes priority over a simultaneous timeout.
    hit_limit = ~both_fin & (cnt_inc == TIMEOUT_C);
    // On timeout, any copy that never finished is charged the full budget.
    lat_1_end = fin_1_nx ? lat_1_nx : TIMEOUT_C;
    lat_2_end = fin_2_nx ? lat_2_nx : TIMEOUT_C;
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      fin_1           <= 1'b0;
      fin_2           <= 1'b0;
      res_1           <= '0;
      res_2           <= '0;
      lat_1           <= '0;
      lat_2           <= '0;
      leak_timing     <= 1'b0;
      result_mismatch <= 1'b0;
      timeout         <= 1'b0;
      delta           <= '0;
    end else begin
      case (state)
        // IDLE: finish/result inputs ignored; arming clears the previous run.
        S_IDLE: begin
          if (KeyGenStart) begin
            state           <= S_RUN;
            cnt             <= '0;
            fin_1           <= 1'b0;
            fin_2           <= 1'b0;
            lat_1           <= '0;
            lat_2           <= '0;
            leak_timing     <= 1'b0;
            result_mismatch <= 1'b0;
            timeout         <= 1'b0;
            delta           <= '0;
          end
        end

        // RUN: count, capture first finish per copy, detect divergence.
        S_RUN: begin
          cnt   <= cnt_inc;
          fin_1 <= fin_1_nx;
          fin_2 <= fin_2_nx;
          lat_1 <= lat_1_nx;
          lat_2 <= lat_2_nx;
          res_1 <= res_1_nx;
          res_2 <= res_2_nx;
          if (fin_1_nx != fin_2_nx) begin
            leak_timing <= 1'b1;
          end
          if (both_fin) begin
            state           <= S_DONE;
            result_mismatch <= (res_1_nx != res_2_nx);
            delta           <= abs_diff(lat_1_nx, lat_2_nx);
          end else if (hit_limit) begin
            state           <= S_DONE;
            timeout         <= 1'b1;
            result_mismatch <= 1'b0;
            lat_1           <= lat_1_end;
            lat_2           <= lat_2_end;
            delta           <= abs_diff(lat_1_end, lat_2_end);
          end
        end

        // DONE: hold results; a still-high KeyGenStart must drop first.
        S_DONE: begin
          if (!KeyGenStart) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
